// File: rtl/mio_bus_responder_if.sv
// mio_bus_responder_if: CPU memory/IO bus between the SCPU (master) and the responder (slave).
// The master drives a request strobe, a byte address, store data and a write enable.
// The slave returns load data and a one-cycle ready pulse.

interface mio_bus_responder_if;
    logic        mio_req;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        we_in;
    logic [31:0] rdata_out;
    logic        ready_out;

    modport master (
        output mio_req,
        output addr_in,
        output wdata_in,
        output we_in,
        input  rdata_out,
        input  ready_out
    );

    modport slave (
        input  mio_req,
        input  addr_in,
        input  wdata_in,
        input  we_in,
        output rdata_out,
        output ready_out
    );
endinterface

// File: rtl/mio_bus_responder.sv
// mio_bus_responder: slave end of the CPU memory/IO bus.
// Each request goes to a word-addressed data RAM or to a memory-mapped IO register. The
// responder inserts WAIT_CYCLES wait states, then pulses ready_out for one cycle.
// Optional feature: define MIO_CYCLE_COUNTER_EN to add a 32-bit free-running cycle counter
// at IO_BASE+0x8. Without the macro, no counter logic is built and that address is unmapped.

module mio_bus_responder #(
    parameter int unsigned RAM_AW      = 10,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] IO_BASE     = 32'hF000_0000
) (
    input  logic               clk,
    input  logic               reset,
    mio_bus_responder_if.slave bus,
    input  logic [15:0]        sw_in,
    output logic [15:0]        led_out
);

    localparam int unsigned RamDepth = 2 ** RAM_AW;
    localparam logic [3:0]  WaitLast = 4'(WAIT_CYCLES);
    localparam logic [31:0] LedAddr  = IO_BASE;
    localparam logic [31:0] SwAddr   = IO_BASE + 32'h4;
`ifdef MIO_CYCLE_COUNTER_EN
    localparam logic [31:0] CntAddr  = IO_BASE + 32'h8;
`endif

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [29:0]       req_word_q, req_word_d;   // latched address, word granularity
    logic [31:0]       req_wdata_q, req_wdata_d;
    logic              req_we_q, req_we_d;
    logic [15:0]       led_q;
    logic [31:0]       ram_q [RamDepth];
    logic [31:0]       ram_rdata_q;
    logic [RAM_AW-1:0] ram_raddr;
    logic              ram_re;
    logic              ram_we;
    logic              ram_hit;
    logic              led_hit;
    logic              sw_hit;
    logic              ack;
    logic              ack_we;
    logic [31:0]       rd_val;

    // Request FSM state and latched request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            req_word_q  <= '0;
            req_wdata_q <= '0;
            req_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            req_word_q  <= req_word_d;
            req_wdata_q <= req_wdata_d;
            req_we_q    <= req_we_d;
        end
    end

    // Next state: accept in IDLE, count wait states, one ACK cycle, back to IDLE.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        req_word_d  = req_word_q;
        req_wdata_d = req_wdata_q;
        req_we_d    = req_we_q;
        unique case (state_q)
            StIdle: begin
                if (bus.mio_req) begin
                    req_word_d  = bus.addr_in[31:2];
                    req_wdata_d = bus.wdata_in;
                    req_we_d    = bus.we_in;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = StAck;
                        wait_cnt_d = '0;
                    end else begin
                        state_d    = StWait;
                        wait_cnt_d = 4'd1;
                    end
                end
            end
            StWait: begin
                if (wait_cnt_q == WaitLast) begin
                    state_d    = StAck;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Address decode of the latched request; RAM read address timed so data lands in ACK.
    always_comb begin
        ack     = (state_q == StAck);
        ack_we  = ack && req_we_q && !reset;
        ram_hit = (req_word_q[29:26] == 4'h0) && ((req_word_q >> RAM_AW) == 30'd0);
        led_hit = (req_word_q == LedAddr[31:2]);
        sw_hit  = (req_word_q == SwAddr[31:2]);
        ram_we  = ack_we && ram_hit;
        if (WAIT_CYCLES == 0) begin
            // No wait states: the RAM sees the live bus address during the accept cycle.
            ram_re    = (state_q == StIdle);
            ram_raddr = bus.addr_in[RAM_AW+1:2];
        end else begin
            ram_re    = (state_q == StWait) && (wait_cnt_q == WaitLast);
            ram_raddr = req_word_q[RAM_AW-1:0];
        end
    end

    // Word RAM: synchronous read, store committed on the ACK edge. Contents are not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[req_word_q[RAM_AW-1:0]] <= req_wdata_q;
        end
        if (ram_re) begin
            ram_rdata_q <= ram_q[ram_raddr];
        end
    end

    // LED register, written by stores to IO_BASE+0x0.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q <= '0;
        end else if (ack_we && led_hit) begin
            led_q <= req_wdata_q[15:0];
        end
    end

`ifdef MIO_CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt_q;
    logic        cnt_hit;

    assign cnt_hit = (req_word_q == CntAddr[31:2]);

    // Free-running cycle counter; a store loads it and counting resumes from the loaded value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
        end else if (ack_we && cnt_hit) begin
            cycle_cnt_q <= req_wdata_q;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end
`endif

    // Load data mux; unmapped addresses read as zero.
    always_comb begin
        rd_val = '0;
        if (ram_hit) begin
            rd_val = ram_rdata_q;
        end else if (led_hit) begin
            rd_val = {16'h0000, led_q};
        end else if (sw_hit) begin
            rd_val = {16'h0000, sw_in};
`ifdef MIO_CYCLE_COUNTER_EN
        end else if (cnt_hit) begin
            rd_val = cycle_cnt_q;
`endif
        end
    end

    // Bus outputs: ready only in ACK, masked by a reset arriving in that cycle.
    always_comb begin
        bus.ready_out = ack && !reset;
        bus.rdata_out = (ack && !reset && !req_we_q) ? rd_val : 32'h0;
        led_out       = led_q;
    end

endmodule
